proc_trace_buffer: RTL and testbench
====================================

Name: proc_trace_buffer

Overview:
- Downstream observer of the processor's debug outputs (IR, PC, State, ALU result).
- Captures one trace record per executed instruction into an internal FIFO.
- A host (UART bridge, display scanner) drains the records through a valid/ready read port.
- Freezes capture once the processor reaches HALT, so the full program trace survives for readout.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 4 to 64.
- EXEC_STATE, 4'd3, processor FSM state in which the ALU result of the current instruction is valid.
- HALT_STATE, 4'd9, processor FSM state encoding for HALT.

Ports:
- clk  input  1  system clock, same clock as the processor.
- Reset  input  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clk).
- trace_en  input  1  capture enable; 0 suppresses new captures and leaves contents intact.
- State_In  input  4  processor current state.
- PC_In  input  7  processor program counter.
- IR_In  input  16  processor instruction register.
- ALU_Out_In  input  16  processor ALU output.
- rd_valid  output  1  head record available.
- rd_ready  input  1  host accepts the head record.
- rd_data  output  39 (55 with TRACE_TIMESTAMP_EN)  head record, packed {PC[6:0], IR[15:0], ALU[15:0]}, PC in the MSBs.
- count  output  $clog2(DEPTH)+1  number of stored records.
- drop_count  output  8  records lost to overflow, saturating at 255.
- halted  output  1  HALT observed; capture frozen.

Behaviour:
- Reset (Reset==0 at an edge):
  - FIFO is emptied; count=0, rd_valid=0, rd_data=0.
  - drop_count=0, halted=0, prev_state register=0.
  - Reset wins over every other event in the same cycle, including in-flight push and pop.
- Capture strobe:
  - cap = trace_en & ~halted & (State_In==EXEC_STATE) & (prev_state!=EXEC_STATE).
  - prev_state is State_In registered every cycle.
  - The strobe therefore fires once per entry into EXEC_STATE, however long the processor stays there.
- Push:
  - On a cap edge the sampled {PC_In, IR_In, ALU_Out_In} are written at the tail.
  - Latency: rd_valid rises on the edge after the write. There is no fall-through.
- Pop:
  - When rd_valid & rd_ready at an edge, the head advances.
  - rd_data is driven combinationally from the head storage slot and is stable while rd_valid=1 and rd_ready=0.
  - rd_ready while empty is ignored.
- Simultaneous push and pop:
  - When not full, both occur and count is unchanged.
  - When full, the pop frees the slot and the push is accepted with no drop.
  - When empty, only the push takes effect.
- Overflow: a push while full without a pop discards the new record. drop_count increments, saturating at 255, and contents are unchanged.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are decided from count.
- Halt:
  - On the first edge where State_In==HALT_STATE and prev_state!=HALT_STATE, halted is set to 1.
  - halted stays 1 until reset; reads continue normally.
  - If the same edge also produces a cap, the capture is performed, so the instruction preceding HALT is not lost.
- trace_en deasserted: no capture and no drop counting.
- Reset mid-readout: contents are lost, and rd_valid is 0 on the edge after the reset edge.

Optional Feature:
- TRACE_TIMESTAMP_EN defined:
  - Adds a 16-bit free-running cycle counter, cleared by reset and wrapping 0xFFFF to 0.
  - Each record is prefixed with the counter value sampled at capture, so rd_data is 55 bits: {ts[15:0], PC, IR, ALU}.
  - The counter keeps running after halted=1.
- Not defined: no counter logic exists and rd_data is 39 bits.

Decomposition:
- Shared package proc_trace_pkg holds:
  - the trace_rec_t packed struct {pc, ir, alu} and its timestamped variant under the macro;
  - width constants PC_W=7, IR_W=16, ALU_W=16, TS_W=16;
  - state constants ST_EXEC=4'd3 and ST_HALT=4'd9, used as parameter defaults.
- Sub-module trace_fifo is a generic synchronous FIFO (DEPTH, WIDTH) with push/pop/full/empty/count.
- The top level adds capture-edge detection, the halt latch, drop counting and the timestamp.

Test Plan:
- Reset held at 0 for 3 cycles with State_In toggling into 3 → rd_valid=0, count=0, drop_count=0, halted=0 throughout.
- Three EXEC entries (State 1→3→1, PC=1/2/3, IR=16'h1234/16'h2345/16'h3456, ALU=5/10/15), rd_ready=0 → count=3. Then rd_ready=1 → rd_data order is {1,1234,5}, {2,2345,10}, {3,3456,15}, then rd_valid=0.
- State_In held at 3 for 5 cycles → exactly one record captured.
- Overflow:
  - 18 captures with rd_ready=0 and DEPTH=16 → count=16, drop_count=2, and the head is the first record.
  - Then a capture on the same edge as a pop → count stays 16 and drop_count stays 2.
- Halt: capture PC=4, then State_In=9 → halted=1. A later EXEC entry with PC=5 is not captured, and readout yields only the PC=4 record.
- With TRACE_TIMESTAMP_EN: captures at cycles 10 and 25 after reset release → rd_data[54:39]=10 then 25. A 300-capture overflow run → drop_count saturates at 255.

Source files
------------

// File: rtl/proc_trace_pkg.sv
// Shared types and constants for the processor trace buffer.
// Record layout is {pc, ir, alu}; a 16-bit timestamp is prepended when
// TRACE_TIMESTAMP_EN is defined.
package proc_trace_pkg;

   localparam int PC_W  = 7;
   localparam int IR_W  = 16;
   localparam int ALU_W = 16;
   localparam int TS_W  = 16;

   // Processor FSM encodings the buffer cares about.
   localparam logic [3:0] ST_EXEC = 4'd3;
   localparam logic [3:0] ST_HALT = 4'd9;

   // One executed instruction as seen on the debug outputs.
   typedef struct packed {
      logic [PC_W-1:0]  pc;
      logic [IR_W-1:0]  ir;
      logic [ALU_W-1:0] alu;
   } trace_rec_t;

`ifdef TRACE_TIMESTAMP_EN
   // Timestamped record: cycle count at capture in the MSBs.
   typedef struct packed {
      logic [TS_W-1:0] ts;
      trace_rec_t      rec;
   } trace_ts_rec_t;

   typedef trace_ts_rec_t trace_entry_t;
`else
   typedef trace_rec_t trace_entry_t;
`endif

   // Width of one stored entry (39 plain, 55 timestamped).
   localparam int REC_W = $bits(trace_entry_t);

   // 8-bit increment that sticks at all-ones instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO storing WIDTH-bit entries, DEPTH deep.
// Latency: a push is visible at the head one edge later (no fall-through).
// Backpressure: a push while full is accepted only if a pop frees a slot on the same edge.
module trace_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 39,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   // Occupancy alone decides full/empty; pointers just wrap modulo DEPTH.
   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   // Pop of an empty FIFO is ignored; a full FIFO takes a push only alongside a pop.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   // Empty FIFO presents zeros so the head never shows stale or unwritten storage.
   assign head_data = empty ? '0 : mem[rd_ptr];

   // Pointer and occupancy bookkeeping; reset overrides any in-flight push/pop.
   always_ff @(posedge clk) begin
      if (!Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array is not reset; the empty gate on head_data hides its contents.
   always_ff @(posedge clk) begin
      if (Reset && push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/proc_trace_buffer.sv
// Captures one {PC, IR, ALU} record per EXEC entry of the processor; freezes on HALT.
// Latency: record visible on rd_data one edge after capture; rd_data is combinational from the head.
// Backpressure: host stalls with rd_ready=0; captures into a full buffer are dropped and counted.
// Optional macro TRACE_TIMESTAMP_EN prefixes each record with a 16-bit cycle count.
module proc_trace_buffer
   import proc_trace_pkg::*;
#(
   parameter int         DEPTH      = 16,
   parameter logic [3:0] EXEC_STATE = ST_EXEC,
   parameter logic [3:0] HALT_STATE = ST_HALT,
   localparam int        CNT_W      = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              trace_en,
   input  logic [3:0]        State_In,
   input  logic [PC_W-1:0]   PC_In,
   input  logic [IR_W-1:0]   IR_In,
   input  logic [ALU_W-1:0]  ALU_Out_In,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [REC_W-1:0]  rd_data,
   output logic [CNT_W-1:0]  count,
   output logic [7:0]        drop_count,
   output logic              halted
);

   logic [3:0]   prev_state;
   logic         cap;
   logic         halt_edge;
   logic         pop;
   logic         fifo_full;
   logic         fifo_empty;
   trace_entry_t rec;

   // Edge-detect entry into EXEC so a multi-cycle EXEC yields a single record.
   // The pre-update value of halted is used, so an instruction captured on the
   // HALT edge itself is still stored.
   assign cap       = trace_en & ~halted
                    & (State_In == EXEC_STATE) & (prev_state != EXEC_STATE);
   assign halt_edge = (State_In == HALT_STATE) & (prev_state != HALT_STATE);
   assign pop       = rd_valid & rd_ready;
   assign rd_valid  = ~fifo_empty;

`ifdef TRACE_TIMESTAMP_EN
   logic [TS_W-1:0] ts_cnt;

   // Free-running cycle counter; keeps running after halt so later host timing is visible.
   always_ff @(posedge clk) begin
      if (!Reset) begin
         ts_cnt <= '0;
      end else begin
         ts_cnt <= ts_cnt + TS_W'(1);
      end
   end

   assign rec = {ts_cnt, PC_In, IR_In, ALU_Out_In};
`else
   assign rec = {PC_In, IR_In, ALU_Out_In};
`endif

   // Previous-state register feeding both edge detectors.
   always_ff @(posedge clk) begin
      if (!Reset) begin
         prev_state <= 4'd0;
      end else begin
         prev_state <= State_In;
      end
   end

   // Sticky halt flag; only reset clears it.
   always_ff @(posedge clk) begin
      if (!Reset) begin
         halted <= 1'b0;
      end else if (halt_edge) begin
         halted <= 1'b1;
      end
   end

   // Count captures lost to a full buffer; a same-edge pop makes room so nothing is lost.
   always_ff @(posedge clk) begin
      if (!Reset) begin
         drop_count <= 8'd0;
      end else if (cap && fifo_full && !pop) begin
         drop_count <= sat_inc8(drop_count);
      end
   end

   trace_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (REC_W)
   ) u_fifo (
      .clk       (clk),
      .Reset     (Reset),
      .push      (cap),
      .push_data (rec),
      .pop       (rd_ready),
      .head_data (rd_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (count)
   );

endmodule

// File: tb/tb_proc_trace_buffer.sv
// Self-checking bench for proc_trace_buffer: directed scenarios plus a random
// phase, all compared every cycle against a queue-based reference model.
// Works with or without TRACE_TIMESTAMP_EN defined.
module tb_proc_trace_buffer;
   import proc_trace_pkg::*;

   localparam int DEPTH = 16;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              Reset;
   logic              trace_en;
   logic [3:0]        State_In;
   logic [6:0]        PC_In;
   logic [15:0]       IR_In;
   logic [15:0]       ALU_Out_In;
   logic              rd_valid;
   logic              rd_ready;
   logic [REC_W-1:0]  rd_data;
   logic [CNT_W-1:0]  count;
   logic [7:0]        drop_count;
   logic              halted;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   logic [REC_W-1:0] m_q[$];
   logic [3:0]       m_prev;
   bit               m_halted;
   int               m_drop;
   logic [15:0]      m_ts;

   proc_trace_buffer #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .Reset      (Reset),
      .trace_en   (trace_en),
      .State_In   (State_In),
      .PC_In      (PC_In),
      .IR_In      (IR_In),
      .ALU_Out_In (ALU_Out_In),
      .rd_valid   (rd_valid),
      .rd_ready   (rd_ready),
      .rd_data    (rd_data),
      .count      (count),
      .drop_count (drop_count),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [REC_W-1:0] head;
      head = (m_q.size() != 0) ? m_q[0] : '0;
      chk({tag, ".rd_valid"},   64'(rd_valid),   64'(m_q.size() != 0));
      chk({tag, ".count"},      64'(count),      64'(m_q.size()));
      chk({tag, ".drop_count"}, 64'(drop_count), 64'(m_drop));
      chk({tag, ".halted"},     64'(halted),     64'(m_halted));
      chk({tag, ".rd_data"},    64'(rd_data),    64'(head));
   endtask

   // Apply one clock edge to the model (from the spec's rules) and the DUT, then compare.
   task automatic tick(input string tag);
      logic [REC_W-1:0] rec;
      bit cap, pop;
      if (!Reset) begin
         m_q.delete();
         m_prev   = 4'd0;
         m_halted = 0;
         m_drop   = 0;
         m_ts     = 16'd0;
      end else begin
         cap = trace_en && !m_halted && (State_In == 4'd3) && (m_prev != 4'd3);
         pop = rd_ready && (m_q.size() != 0);
`ifdef TRACE_TIMESTAMP_EN
         rec = {m_ts, PC_In, IR_In, ALU_Out_In};
`else
         rec = {PC_In, IR_In, ALU_Out_In};
`endif
         if (pop) void'(m_q.pop_front());
         if (cap) begin
            if (m_q.size() < DEPTH) m_q.push_back(rec);
            else if (m_drop < 255) m_drop++;
         end
         if ((State_In == 4'd9) && (m_prev != 4'd9)) m_halted = 1;
         m_prev = State_In;
         m_ts   = m_ts + 16'd1;
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic capture(input logic [6:0] pc, input logic [15:0] ir, input logic [15:0] alu,
                          input string tag);
      State_In = 4'd3; PC_In = pc; IR_In = ir; ALU_Out_In = alu;
      tick(tag);
      State_In = 4'd1;
      tick(tag);
   endtask

   task automatic drain(input string tag);
      rd_ready = 1'b1;
      for (int i = 0; i < DEPTH + 2 && rd_valid; i++) tick(tag);
      chk({tag, ".drained"}, 64'(rd_valid), 64'(0));
      rd_ready = 1'b0;
   endtask

   task automatic do_reset();
      Reset = 1'b0;
      tick("reset");
      Reset = 1'b1;
   endtask

   initial begin
      Reset = 1'b0; trace_en = 1'b1; State_In = 4'd1; PC_In = '0; IR_In = '0;
      ALU_Out_In = '0; rd_ready = 1'b0;

      // Reset held with State_In toggling into EXEC
      for (int i = 0; i < 3; i++) begin
         State_In = (i == 1) ? 4'd3 : 4'd1;
         tick("rst_hold");
         chk("rst_hold.count_zero", 64'(count), 64'(0));
      end
      Reset = 1'b1; State_In = 4'd1;
      tick("rst_release");

      // Three EXEC entries, then ordered readout
      capture(7'd1, 16'h1234, 16'd5,  "three");
      capture(7'd2, 16'h2345, 16'd10, "three");
      capture(7'd3, 16'h3456, 16'd15, "three");
      chk("three.count", 64'(count), 64'(3));
      rd_ready = 1'b1;
      chk("three.head1", 64'(rd_data[38:0]), {25'd0, 7'd1, 16'h1234, 16'd5});
      tick("three_rd");
      chk("three.head2", 64'(rd_data[38:0]), {25'd0, 7'd2, 16'h2345, 16'd10});
      tick("three_rd");
      chk("three.head3", 64'(rd_data[38:0]), {25'd0, 7'd3, 16'h3456, 16'd15});
      tick("three_rd");
      chk("three.empty", 64'(rd_valid), 64'(0));
      rd_ready = 1'b0;

      // Long EXEC residence yields one record
      State_In = 4'd3; PC_In = 7'd9;
      for (int i = 0; i < 5; i++) tick("hold3");
      State_In = 4'd1;
      tick("hold3");
      chk("hold3.count", 64'(count), 64'(1));
      drain("hold3");

      // Overflow: 18 captures into 16 slots
      do_reset();
      for (int i = 0; i < 18; i++) capture(7'(i + 1), 16'(i * 3), 16'(i), "ovf");
      chk("ovf.count", 64'(count), 64'(16));
      chk("ovf.drop", 64'(drop_count), 64'(2));
      chk("ovf.head_pc", 64'(rd_data[38:32]), 64'(1));
      // Capture on the same edge as a pop while full
      State_In = 4'd3; PC_In = 7'd100; rd_ready = 1'b1;
      tick("ovf_pop");
      rd_ready = 1'b0; State_In = 4'd1;
      chk("ovf_pop.count", 64'(count), 64'(16));
      chk("ovf_pop.drop", 64'(drop_count), 64'(2));
      tick("ovf_pop");
      drain("ovf");

      // Halt freezes capture
      capture(7'd4, 16'hAAAA, 16'd44, "halt");
      State_In = 4'd9;
      tick("halt");
      chk("halt.flag", 64'(halted), 64'(1));
      State_In = 4'd1; tick("halt");
      capture(7'd5, 16'hBBBB, 16'd55, "halt");
      chk("halt.count", 64'(count), 64'(1));
      chk("halt.head_pc", 64'(rd_data[38:32]), 64'(4));
      drain("halt");
      chk("halt.sticky", 64'(halted), 64'(1));

      // Reset during readout
      do_reset();
      capture(7'd6, 16'h0006, 16'd6, "midrst");
      capture(7'd7, 16'h0007, 16'd7, "midrst");
      rd_ready = 1'b1;
      tick("midrst");
      Reset = 1'b0;
      tick("midrst");
      chk("midrst.valid", 64'(rd_valid), 64'(0));
      Reset = 1'b1; rd_ready = 1'b0;
      tick("midrst");

      // Drop counter saturation
      do_reset();
      for (int i = 0; i < 300; i++) capture(7'(i), 16'(i), 16'(~i), "sat");
      chk("sat.drop", 64'(drop_count), 64'(255));
      chk("sat.count", 64'(count), 64'(16));
      drain("sat");

`ifdef TRACE_TIMESTAMP_EN
      // Captures at cycles 10 and 25 after reset release
      Reset = 1'b0; State_In = 4'd1;
      tick("ts");
      Reset = 1'b1;
      for (int k = 0; k < 27; k++) begin
         State_In = (k == 10 || k == 25) ? 4'd3 : 4'd1;
         tick("ts");
      end
      chk("ts.first", 64'(rd_data[54:39]), 64'(10));
      rd_ready = 1'b1;
      tick("ts");
      chk("ts.second", 64'(rd_data[54:39]), 64'(25));
      tick("ts");
      rd_ready = 1'b0;
`endif

      // Random phase against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = int'($urandom_range(0, 999));
         Reset      = ($urandom_range(0, 149) != 0);
         trace_en   = ($urandom_range(0, 9) != 0);
         rd_ready   = ($urandom_range(0, 9) < 3);
         State_In   = (r < 400) ? 4'd3 : (r < 405) ? 4'd9 : 4'($urandom_range(0, 2));
         PC_In      = 7'($urandom);
         IR_In      = 16'($urandom);
         ALU_Out_In = 16'($urandom);
         tick("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
